// File: rtl/uart_sample_loader.sv
// ---------------------------------------------------------------------------
// uart_sample_loader
//
// Receives 8N1 bytes from the host on uart_rxd, pairs them big-endian
// (high byte first) into 16-bit samples and writes each sample into the
// sample RAM with a single-cycle strobe. A load is started by a one-cycle
// arm pulse and completes after NUM_SAMPLES samples, at which point done
// is raised and further bytes are ignored until the next arm.
//
// Optional build macro:
//   RX_TIMEOUT_EN  - when defined, an inter-byte timeout discards a dangling
//                    high byte after TIMEOUT_BITS bit-times and raises the
//                    sticky rx_timeout flag. When undefined, rx_timeout is
//                    tied to 0 and the loader waits indefinitely for the low
//                    byte.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   ADDR_W        sample RAM address width
//   NUM_SAMPLES   samples per load (<= 2**ADDR_W)
//   TIMEOUT_BITS  bit-times allowed between high and low byte
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   uart_rxd        asynchronous UART line, idles high
//   arm             one-cycle pulse that starts a new load
//   ram_write_en    one-cycle sample RAM write strobe
//   ram_write_addr  write address (holds after the strobe)
//   ram_data_in     sample word {hi_byte, lo_byte} (holds after the strobe)
//   busy            load in progress
//   done            NUM_SAMPLES samples written; sticky until arm/reset
//   frame_err       sticky: a stop bit was sampled low
//   rx_timeout      sticky inter-byte timeout
//   sample_count    samples written since the last arm
// ---------------------------------------------------------------------------
module uart_sample_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned NUM_SAMPLES  = 16384,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rxd,
    input  logic              arm,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [15:0]       ram_data_in,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              rx_timeout,
    output logic [ADDR_W:0]   sample_count
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(NUM_SAMPLES - 1);

`ifdef RX_TIMEOUT_EN
    localparam int unsigned       TMO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned       TMO_W    = $clog2(TMO_CLKS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CLKS - 1);
`endif

    // Elaboration-time parameter sanity check.
    generate
        if (CLKS_PER_BIT < 4 || NUM_SAMPLES == 0 ||
            NUM_SAMPLES > (1 << ADDR_W) || TIMEOUT_BITS == 0) begin : g_bad_params
            $error("uart_sample_loader: illegal parameter combination");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State encodings
    // -----------------------------------------------------------------------
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_LOAD  = 2'd1;
    localparam logic [1:0] L_DONE  = 2'd2;

    // -----------------------------------------------------------------------
    // Receiver signals
    // -----------------------------------------------------------------------
    logic              rx_meta;
    logic              rxs;
    logic              rxs_d;
    logic [2:0]        rstate;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_shift;
    logic              byte_valid;
    logic              frame_evt;

    // -----------------------------------------------------------------------
    // Loader signals
    // -----------------------------------------------------------------------
    logic [1:0]        lstate;
    logic              phase;
    logic [7:0]        hi_byte;

`ifdef RX_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rx_timeout_q;
`endif

    // -----------------------------------------------------------------------
    // Receiver: 2-flop synchroniser, edge detect and 8N1 bit FSM.
    // Runs regardless of loader state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            rstate     <= R_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_evt  <= 1'b0;
        end else begin
            rx_meta    <= uart_rxd;
            rxs        <= rx_meta;
            rxs_d      <= rxs;
            byte_valid <= 1'b0;
            frame_evt  <= 1'b0;

            case (rstate)
                R_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (rxs_d && !rxs) begin
                        rstate <= R_START;
                    end
                end

                // Re-check the start bit at its midpoint to reject glitches.
                R_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        rstate   <= rxs ? R_IDLE : R_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Counter was aligned to mid-start-bit, so full-bit
                // intervals land mid-bit; data arrives LSB first.
                R_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rstate <= R_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                R_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            rstate     <= R_IDLE;
                        end else begin
                            frame_evt <= 1'b1;
                            rstate    <= R_WAIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Line held low past a bad stop bit: wait for it to idle
                // before looking for the next start edge.
                R_WAIT: begin
                    if (rxs) begin
                        rstate <= R_IDLE;
                    end
                end

                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Loader: pairs bytes into samples and drives the RAM write port.
    // rx_shift stays stable while byte_valid is high (receiver is idle).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            lstate         <= L_IDLE;
            phase          <= 1'b0;
            hi_byte        <= '0;
            ram_write_en   <= 1'b0;
            ram_write_addr <= '0;
            ram_data_in    <= '0;
            sample_count   <= '0;
            done           <= 1'b0;
            frame_err      <= 1'b0;
`ifdef RX_TIMEOUT_EN
            tmo_cnt        <= '0;
            rx_timeout_q   <= 1'b0;
`endif
        end else begin
            ram_write_en <= 1'b0;

            // arm takes priority over a byte arriving in the same cycle.
            if (arm) begin
                lstate         <= L_LOAD;
                phase          <= 1'b0;
                sample_count   <= '0;
                ram_write_addr <= '0;
                done           <= 1'b0;
                frame_err      <= 1'b0;
`ifdef RX_TIMEOUT_EN
                tmo_cnt        <= '0;
                rx_timeout_q   <= 1'b0;
`endif
            end else if (lstate == L_LOAD) begin
                if (byte_valid) begin
`ifdef RX_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (!phase) begin
                        hi_byte <= rx_shift;
                        phase   <= 1'b1;
                    end else begin
                        ram_write_en   <= 1'b1;
                        ram_data_in    <= {hi_byte, rx_shift};
                        ram_write_addr <= sample_count[ADDR_W-1:0];
                        sample_count   <= sample_count + 1'b1;
                        phase          <= 1'b0;
                        if (sample_count == LAST_COUNT) begin
                            lstate <= L_DONE;
                            done   <= 1'b1;
                        end
                    end
                end
`ifdef RX_TIMEOUT_EN
                else if (phase) begin
                    // Dangling high byte: give up after the timeout window.
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt      <= '0;
                        phase        <= 1'b0;
                        rx_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end else begin
                    tmo_cnt <= '0;
                end
`endif
            end

            // A framing error coinciding with arm still gets reported.
            if (frame_evt) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign busy = (lstate == L_LOAD);

`ifdef RX_TIMEOUT_EN
    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_sample_loader
//
// Directed bench for uart_sample_loader with CLKS_PER_BIT=4, ADDR_W=2,
// NUM_SAMPLES=4, TIMEOUT_BITS=20. Honours RX_TIMEOUT_EN when defined.
// ---------------------------------------------------------------------------
module tb_uart_sample_loader;

    localparam int CPB    = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              uart_rxd;
    logic              arm;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [15:0]       ram_data_in;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic              rx_timeout;
    logic [ADDR_W:0]   sample_count;

    int total      = 0;
    int bad        = 0;
    int wr_cnt     = 0;
    int exp_writes = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [15:0]       last_data = '0;

    uart_sample_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .NUM_SAMPLES  (4),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .uart_rxd       (uart_rxd),
        .arm            (arm),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_data_in    (ram_data_in),
        .busy           (busy),
        .done           (done),
        .frame_err      (frame_err),
        .rx_timeout     (rx_timeout),
        .sample_count   (sample_count)
    );

    always #5 clk = ~clk;

    // Record every strobe cycle; a stuck strobe shows up as extra writes.
    always @(negedge clk) begin
        if (ram_write_en === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = ram_write_addr;
            last_data = ram_data_in;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n posedges and settle 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop;
        tick(CPB);
        uart_rxd = 1'b1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a,
                                input logic [15:0] d);
        exp_writes++;
        for (int i = 0; i < 20 && wr_cnt < exp_writes; i++) tick(1);
        check({tag, "_cnt"},  32'(wr_cnt),    32'(exp_writes));
        check({tag, "_addr"}, 32'(last_addr), 32'(a));
        check({tag, "_data"}, 32'(last_data), 32'(d));
    endtask

    initial begin
        reset    = 1'b0;
        uart_rxd = 1'b1;
        arm      = 1'b0;
        tick(3);

        // Reset state
        check("rst_we",    32'(ram_write_en),   32'd0);
        check("rst_addr",  32'(ram_write_addr), 32'd0);
        check("rst_data",  32'(ram_data_in),    32'd0);
        check("rst_busy",  32'(busy),           32'd0);
        check("rst_done",  32'(done),           32'd0);
        check("rst_ferr",  32'(frame_err),      32'd0);
        check("rst_tmo",   32'(rx_timeout),     32'd0);
        check("rst_count", 32'(sample_count),   32'd0);

        reset = 1'b1;
        tick(4);
        check("idle_busy", 32'(busy), 32'd0);

        // 1: single sample, exact strobe timing
        pulse_arm();
        check("t1_busy_armed", 32'(busy), 32'd1);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t1_lat_early", 32'(ram_write_en), 32'd0);
        @(negedge clk);
        check("t1_strobe",    32'(ram_write_en),   32'd1);
        check("t1_addr",      32'(ram_write_addr), 32'd0);
        check("t1_data",      32'(ram_data_in),    32'h1234);
        @(negedge clk);
        check("t1_pulse_end", 32'(ram_write_en),   32'd0);
        check("t1_hold_data", 32'(ram_data_in),    32'h1234);
        @(posedge clk);
        #1;
        exp_writes++;
        check("t1_wr_cnt", 32'(wr_cnt),       32'(exp_writes));
        check("t1_count",  32'(sample_count), 32'd1);
        check("t1_busy",   32'(busy),         32'd1);

        // 2: full load, re-arm mid-load restarts at address 0
        pulse_arm();
        check("t2_arm_count", 32'(sample_count), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'h00, 1'b1);
            send_frame(8'(k), 1'b1);
            expect_write("t2_w", ADDR_W'(k - 1), 16'(k));
        end
        check("t2_done",  32'(done),         32'd1);
        check("t2_busy",  32'(busy),         32'd0);
        check("t2_count", 32'(sample_count), 32'd4);
        send_frame(8'h00, 1'b1);
        send_frame(8'h05, 1'b1);
        tick(10);
        check("t2_no_extra_write", 32'(wr_cnt),         32'(exp_writes));
        check("t2_no_wrap_addr",   32'(ram_write_addr), 32'd3);
        check("t2_done_sticky",    32'(done),           32'd1);
        check("t2_count_hold",     32'(sample_count),   32'd4);

        // 3: framing error drops only the bad byte
        pulse_arm();
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_busy",     32'(busy), 32'd1);
        send_frame(8'hA5, 1'b0);
        tick(8);
        check("t3_ferr",     32'(frame_err), 32'd1);
        check("t3_no_write", 32'(wr_cnt),    32'(exp_writes));
        send_frame(8'hAB, 1'b1);
        send_frame(8'hCD, 1'b1);
        expect_write("t3_w", 2'd0, 16'hABCD);
        check("t3_ferr_sticky", 32'(frame_err), 32'd1);

        // 4: one-clock glitch is rejected
        pulse_arm();
        check("t4_ferr_clr", 32'(frame_err), 32'd0);
        uart_rxd = 1'b0;
        tick(1);
        uart_rxd = 1'b1;
        tick(12);
        check("t4_no_write", 32'(wr_cnt),       32'(exp_writes));
        check("t4_ferr",     32'(frame_err),    32'd0);
        check("t4_count",    32'(sample_count), 32'd0);
        send_frame(8'hFF, 1'b1);
        send_frame(8'hEE, 1'b1);
        expect_write("t4_w", 2'd0, 16'hFFEE);

        // 5: arm coincident with the low byte's byte_valid wins
        pulse_arm();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(1);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(10);
        check("t5_no_write", 32'(wr_cnt),       32'(exp_writes));
        check("t5_count",    32'(sample_count), 32'd0);
        check("t5_busy",     32'(busy),         32'd1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        expect_write("t5_w", 2'd0, 16'h3344);

        // 6: dangling high byte, then inter-byte idle
        pulse_arm();
        send_frame(8'h55, 1'b1);
        tick(100);
        check("t6_no_write", 32'(wr_cnt), 32'(exp_writes));
`ifdef RX_TIMEOUT_EN
        check("t6_timeout", 32'(rx_timeout), 32'd1);
        send_frame(8'h66, 1'b1);
        send_frame(8'h77, 1'b1);
        expect_write("t6_w", 2'd0, 16'h6677);
        check("t6_timeout_sticky", 32'(rx_timeout), 32'd1);
`else
        check("t6_timeout", 32'(rx_timeout), 32'd0);
        send_frame(8'h66, 1'b1);
        send_frame(8'h77, 1'b1);
        expect_write("t6_w", 2'd0, 16'h5566);
`endif

        // Reset mid-byte clears every output on the next clock
        uart_rxd = 1'b0;
        tick(10);
        reset = 1'b0;
        tick(1);
        check("mrst_we",    32'(ram_write_en),   32'd0);
        check("mrst_addr",  32'(ram_write_addr), 32'd0);
        check("mrst_data",  32'(ram_data_in),    32'd0);
        check("mrst_busy",  32'(busy),           32'd0);
        check("mrst_done",  32'(done),           32'd0);
        check("mrst_ferr",  32'(frame_err),      32'd0);
        check("mrst_tmo",   32'(rx_timeout),     32'd0);
        check("mrst_count", 32'(sample_count),   32'd0);
        uart_rxd = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(5);
        check("post_rst_no_write", 32'(wr_cnt), 32'(exp_writes));
        check("post_rst_busy",     32'(busy),   32'd0);
        pulse_arm();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        expect_write("post_rst_w", 2'd0, 16'h0102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
